// File: rtl/deserializer_pkg.sv
// Shared constants and FSM state type for the serial-to-parallel deserializer.
package deserializer_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int MOD_W      = $clog2(DATA_W_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;
endpackage

// File: rtl/deserializer_idle_timer.sv
// Counts consecutive enabled cycles; expired pulses on the cycle the count reaches TIMEOUT.
module deserializer_idle_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i) cnt <= '0;
    else if (cnt_en_i)   cnt <= cnt + 1'b1;
  end

  // Fires combinationally on the cycle that would make the count equal TIMEOUT.
  assign expired_o = cnt_en_i && (cnt == LAST);
endmodule

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel deserializer. Define DESER_FLUSH_EN to enable
// partial-word flush after TIMEOUT idle cycles.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 8
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_W-1:0]         deser_data_o,
  output logic [$clog2(DATA_W)-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o
);
  localparam int MW = $clog2(DATA_W);
  localparam logic [MW-1:0] LAST      = MW'(DATA_W - 1);
  localparam logic [MW-1:0] MIN_FLUSH = MW'(3);

  logic [DATA_W-1:0] sh;
  logic [MW-1:0]     cnt;
  logic [MW-1:0]     mod_q;
  state_e            state;
  logic              flush;

`ifdef DESER_FLUSH_EN
  deserializer_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .clr_i     ((state != RECV) || ser_data_val_i),
    .cnt_en_i  ((state == RECV) && !ser_data_val_i),
    .expired_o (flush)
  );
`else
  assign flush = 1'b0;
`endif

  assign deser_data_mod_o = mod_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sh               <= '0;
      cnt              <= '0;
      mod_q            <= '0;
      state            <= IDLE;
      deser_data_o     <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      if (ser_data_val_i) begin
        sh <= {sh[DATA_W-2:0], ser_data_i};
        if (cnt == LAST) begin
          deser_data_o     <= {sh[DATA_W-2:0], ser_data_i};
          mod_q            <= '0;
          deser_data_val_o <= 1'b1;
          cnt              <= '0;
          state            <= IDLE;
        end else begin
          cnt   <= cnt + 1'b1;
          state <= RECV;
        end
      end else if (flush) begin
        // Received bits sit in the low cnt positions; left-align them, zero-fill below.
        if (cnt >= MIN_FLUSH) begin
          deser_data_o     <= sh << (DATA_W - int'(cnt));
          mod_q            <= cnt;
          deser_data_val_o <= 1'b1;
        end
        sh    <= '0;
        cnt   <= '0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed vectors plus randomized traffic
// against a bit-queue reference model. Flush checks need DESER_FLUSH_EN.
module tb_deserializer;
  localparam int W  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         srst = 1'b1, sdi = 1'b0, sdv = 1'b0;
  logic [W-1:0] dout;
  logic [3:0]   dmod;
  logic         dval;

  deserializer #(.DATA_W(W), .TIMEOUT(TO)) dut (
    .clk_i            (clk),
    .srst_i           (srst),
    .ser_data_i       (sdi),
    .ser_data_val_i   (sdv),
    .deser_data_o     (dout),
    .deser_data_mod_o (dmod),
    .deser_data_val_o (dval)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, pulses = 0, last_cyc = 0;
  logic [W-1:0] last_data = '0;
  logic [3:0]   last_mod = '0;

  // Reference model: bits received so far in the current word, plus expected outputs.
  bit           q[$];
  int           idle = 0;
  logic [W-1:0] e_data = '0;
  logic [3:0]   e_mod = '0;
  logic         e_val = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pack_left();
    logic [W-1:0] w = '0;
    for (int i = 0; i < q.size(); i++) w[W-1-i] = q[i];
    return w;
  endfunction

  task automatic model(input logic r, input logic v, input logic b);
    e_val = 1'b0;
    if (r) begin
      q.delete(); idle = 0; e_data = '0; e_mod = '0;
    end else if (v) begin
      q.push_back(b); idle = 0;
      if (q.size() == W) begin
        e_data = pack_left(); e_mod = 0; e_val = 1'b1; q.delete();
      end
    end else begin
`ifdef DESER_FLUSH_EN
      if (q.size() > 0) begin
        idle++;
        if (idle == TO) begin
          if (q.size() >= 3) begin
            e_data = pack_left(); e_mod = 4'(q.size()); e_val = 1'b1;
          end
          q.delete(); idle = 0;
        end
      end
`endif
    end
  endtask

  task automatic step(input logic r, input logic v, input logic b);
    srst = r; sdv = v; sdi = b;
    @(posedge clk);
    cyc++;
    model(r, v, b);
    @(negedge clk);
    chk("cyc_val", 32'(dval), 32'(e_val));
    chk("cyc_data", 32'(dout), 32'(e_data));
    chk("cyc_mod", 32'(dmod), 32'(e_mod));
    if (dval === 1'b1) begin
      pulses++; last_data = dout; last_mod = dmod; last_cyc = cyc;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap_after, input int gap_len);
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, w[W-1-i]);
      if (i == gap_after)
        for (int g = 0; g < gap_len; g++) step(1'b0, 1'b0, 1'($urandom));
    end
  endtask

  typedef struct {
    logic [W-1:0] word;
    int           gap_after;
    int           gap_len;
    logic [W-1:0] exp;
  } vec_t;

  initial begin
    vec_t vt[5];
    int   c1;
    vt[0] = '{16'hA5C3, -1, 0, 16'hA5C3};
    vt[1] = '{16'h8001,  7, 5, 16'h8001};
    vt[2] = '{16'hFFFF, -1, 0, 16'hFFFF};
    vt[3] = '{16'h0000,  0, 3, 16'h0000};
    vt[4] = '{16'h1234, 14, 2, 16'h1234};

    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_data", 32'(dout), 32'h0);
    chk("reset_val", 32'(dval), 32'h0);

    foreach (vt[k]) begin
      pulses = 0;
      send_word(vt[k].word, vt[k].gap_after, vt[k].gap_len);
      chk("vec_pulses", 32'(pulses), 32'd1);
      chk("vec_data", 32'(last_data), 32'(vt[k].exp));
      chk("vec_mod", 32'(last_mod), 32'h0);
    end

    // back-to-back words, no idle between
    pulses = 0;
    send_word(16'hFFFF, -1, 0);
    c1 = last_cyc;
    chk("b2b_first", 32'(last_data), 32'hFFFF);
    send_word(16'h0000, -1, 0);
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_second", 32'(last_data), 32'h0000);
    chk("b2b_spacing", 32'(last_cyc - c1), 32'd16);

    // reset after 9 bits discards the partial word
    pulses = 0;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'($urandom));
    step(1'b1, 1'b1, 1'b1);
    chk("rst_mid_pulses", 32'(pulses), 32'd0);
    send_word(16'h1234, -1, 0);
    chk("rst_mid_pulses2", 32'(pulses), 32'd1);
    chk("rst_mid_data", 32'(last_data), 32'h1234);

`ifdef DESER_FLUSH_EN
    pulses = 0;
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TO; i++) step(1'b0, 1'b0, 1'b0);
    chk("flush_pulses", 32'(pulses), 32'd1);
    chk("flush_data", 32'(last_data), 32'hB000);
    chk("flush_mod", 32'(last_mod), 32'd5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("flush_once", 32'(pulses), 32'd1);

    pulses = 0;
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < TO; i++) step(1'b0, 1'b0, 1'b0);
    chk("short_discard", 32'(pulses), 32'd0);
    send_word(16'hC3A5, -1, 0);
    chk("short_next_pulses", 32'(pulses), 32'd1);
    chk("short_next_data", 32'(last_data), 32'hC3A5);
    chk("short_next_mod", 32'(last_mod), 32'h0);
`endif

    // randomized traffic with occasional resets and long idle runs
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(49) == 0)
        for (int g = 0; g < 10; g++) step(1'b0, 1'b0, 1'($urandom));
      step(1'($urandom_range(99) == 0), 1'($urandom_range(9) < 7), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
